// File: rtl/lif_spike_sequencer.sv
// Host-side sequencer for one LIF neuron: clear, load weights/inputs, run N steps, report spikes.
// Optional first-spike tracking is enabled by defining LIF_SEQ_FIRST_SPIKE_EN.
module lif_spike_sequencer #(
  parameter int STEPS_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [7:0]         cmd_weights,
  input  logic [7:0]         cmd_inputs,
  input  logic [STEPS_W-1:0] cmd_steps,
  output logic               drv_rst_n,
  output logic [7:0]         drv_data,
  output logic               drv_sel_weights,
  output logic               drv_run,
  input  logic               spike_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [STEPS_W-1:0] res_count,
  output logic [STEPS_W-1:0] res_first
);

  typedef enum logic [2:0] {IDLE, CLR, LDW, LDX, RUN, DONE} state_t;

  localparam logic [STEPS_W-1:0] ONE = STEPS_W'(1);

  state_t             state, state_nxt;
  logic               armed;
  logic [7:0]         weights, inputs;
  logic [STEPS_W-1:0] steps, k, count;
  logic               take, last_step;

  assign take      = cmd_valid & cmd_ready;
  assign last_step = (k == steps - ONE);

  // armed keeps cmd_ready and drv_rst_n low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = CLR;
      CLR:     state_nxt = LDW;
      LDW:     state_nxt = LDX;
      LDX:     state_nxt = (steps == '0) ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready       = 1'b0;
    drv_rst_n       = armed;
    drv_data        = 8'h00;
    drv_sel_weights = 1'b0;
    drv_run         = 1'b0;
    res_valid       = 1'b0;
    case (state)
      IDLE: cmd_ready = armed;
      CLR:  drv_rst_n = 1'b0;
      LDW: begin
        drv_sel_weights = 1'b1;
        drv_data        = weights;
      end
      LDX:  drv_data = inputs;
      RUN: begin
        drv_run  = 1'b1;
        drv_data = inputs;
      end
      DONE: res_valid = 1'b1;
      default: ;
    endcase
  end

  // Command payload needs no reset: it is only observed after a capture.
  always_ff @(posedge clk) begin
    if (take) begin
      weights <= cmd_weights;
      inputs  <= cmd_inputs;
      steps   <= cmd_steps;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      count <= '0;
    end else if (take) begin
      k     <= '0;
      count <= '0;
    end else if (state == RUN) begin
      k <= k + ONE;
      if (spike_in) count <= count + ONE;
    end
  end

  assign res_count = count;

`ifdef LIF_SEQ_FIRST_SPIKE_EN
  logic [STEPS_W-1:0] first;

  // All-ones doubles as "no spike yet", since k never exceeds 2^STEPS_W-2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first <= '1;
    end else if (take) begin
      first <= '1;
    end else if (state == RUN && spike_in && first == '1) begin
      first <= k;
    end
  end

  assign res_first = first;
`else
  assign res_first = '1;
`endif

endmodule

// File: tb/tb_lif_spike_sequencer.sv
// Directed bench for lif_spike_sequencer: table-driven commands plus reset, backpressure and mid-run reset sequences.
module tb_lif_spike_sequencer;

`ifdef LIF_SEQ_FIRST_SPIKE_EN
  localparam bit FIRST_EN = 1'b1;
`else
  localparam bit FIRST_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_weights;
  logic [7:0] cmd_inputs;
  logic [7:0] cmd_steps;
  logic       drv_rst_n;
  logic [7:0] drv_data;
  logic       drv_sel_weights;
  logic       drv_run;
  logic       spike_in;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_count;
  logic [7:0] res_first;

  int n_checks = 0;
  int n_fail   = 0;

  lif_spike_sequencer #(.STEPS_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_weights     (cmd_weights),
    .cmd_inputs      (cmd_inputs),
    .cmd_steps       (cmd_steps),
    .drv_rst_n       (drv_rst_n),
    .drv_data        (drv_data),
    .drv_sel_weights (drv_sel_weights),
    .drv_run         (drv_run),
    .spike_in        (spike_in),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_count       (res_count),
    .res_first       (res_first)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    string      name;
    logic [7:0] w;
    logic [7:0] x;
    logic [7:0] n;
    logic [31:0] mask;
    bit         hold;
    logic [7:0] ecount;
    logic [7:0] efirst;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [7:0] ef(input logic [7:0] f);
    return FIRST_EN ? f : 8'hFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Issue one command from IDLE and follow it cycle by cycle through the result handshake.
  task automatic run_cmd(input vec_t v);
    check({v.name, " ready"}, cmd_ready, 1);
    spike_in    = v.hold;
    cmd_valid   = 1'b1;
    cmd_weights = v.w;
    cmd_inputs  = v.x;
    cmd_steps   = v.n;
    tick();
    cmd_valid = 1'b0;
    check({v.name, " clr"}, {drv_rst_n, drv_run, cmd_ready}, 3'b000);
    tick();
    check({v.name, " ldw"}, {drv_rst_n, drv_run, drv_sel_weights, drv_data}, {3'b101, v.w});
    tick();
    check({v.name, " ldx"}, {drv_rst_n, drv_run, drv_sel_weights, drv_data}, {3'b100, v.x});
    for (int k = 0; k < v.n; k++) begin
      tick();
      check({v.name, " run"}, {drv_run, res_valid, drv_data}, {2'b10, v.x});
      spike_in = v.hold | ((k < 32) ? v.mask[k] : 1'b0);
    end
    tick();
    spike_in = 1'b0;
    check({v.name, " done"}, {res_valid, drv_run, drv_sel_weights, drv_data}, {3'b100, 8'h00});
    check({v.name, " count"}, res_count, v.ecount);
    check({v.name, " first"}, res_first, ef(v.efirst));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({v.name, " back to idle"}, {cmd_ready, res_valid, drv_rst_n}, 3'b101);
  endtask

  initial begin
    vecs[0] = '{"load",   8'hA5, 8'h3C, 8'd4,  32'h0,        1'b0, 8'd0, 8'hFF};
    vecs[1] = '{"spikes", 8'h12, 8'h34, 8'd10, 32'h0000_008C, 1'b0, 8'd3, 8'd2};
    vecs[2] = '{"zero_n", 8'h5A, 8'hC3, 8'd0,  32'h0,        1'b1, 8'd0, 8'hFF};
    vecs[3] = '{"one",    8'h01, 8'h02, 8'd1,  32'h1,        1'b0, 8'd1, 8'd0};
    vecs[4] = '{"all",    8'hFF, 8'h00, 8'd5,  32'h1F,       1'b0, 8'd5, 8'd0};
    vecs[5] = '{"late",   8'h80, 8'h7F, 8'd8,  32'h80,       1'b0, 8'd1, 8'd7};
    vecs[6] = '{"mid",    8'h33, 8'h44, 8'd3,  32'h4,        1'b0, 8'd1, 8'd2};

    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_weights = 8'h00;
    cmd_inputs  = 8'h00;
    cmd_steps   = 8'h00;
    spike_in    = 1'b0;
    res_ready   = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset held", {drv_rst_n, res_valid, drv_run, cmd_ready, drv_data}, 12'h000);
    end
    rst_n = 1'b1;
    tick();
    check("reset release", {cmd_ready, drv_rst_n}, 2'b11);

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Backpressure with commands pulsed during RUN and DONE
    cmd_valid   = 1'b1;
    cmd_weights = 8'h11;
    cmd_inputs  = 8'h22;
    cmd_steps   = 8'd3;
    tick();
    cmd_weights = 8'hEE;
    cmd_inputs  = 8'hDD;
    cmd_steps   = 8'd9;
    check("bp clr", {drv_rst_n, cmd_ready}, 2'b00);
    tick();
    check("bp ldw", drv_data, 8'h11);
    tick();
    check("bp ldx", drv_data, 8'h22);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp run", {cmd_ready, drv_run, drv_data}, {2'b01, 8'h22});
      spike_in = (k == 0);
    end
    tick();
    spike_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp hold", {res_valid, cmd_ready, res_count, res_first}, {2'b10, 8'd1, ef(8'd0)});
      tick();
    end
    check("bp still done", res_valid, 1);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp ready after handshake", {cmd_ready, res_valid}, 2'b10);
    tick();
    check("bp no stray command", {cmd_ready, drv_rst_n}, 2'b11);

    // Reset asserted in the middle of a long run
    cmd_valid   = 1'b1;
    cmd_weights = 8'h99;
    cmd_inputs  = 8'h66;
    cmd_steps   = 8'd20;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 6; k++) tick();
    check("mr in run", {drv_run, drv_data}, {1'b1, 8'h66});
    rst_n = 1'b0;
    #1;
    check("mr reset outputs", {drv_rst_n, drv_run, drv_sel_weights, res_valid, cmd_ready, drv_data}, 13'h0000);
    tick();
    check("mr no result", {res_valid, drv_rst_n, res_count}, 10'h000);
    rst_n = 1'b1;
    tick();
    check("mr release", {cmd_ready, drv_rst_n}, 2'b11);
    run_cmd('{"after_reset", 8'h0F, 8'hF0, 8'd1, 32'h0, 1'b1, 8'd1, 8'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
